inc_jno_sequencer: RTL and testbench

- Program reader and executor for the 4-word x 2-bit instruction ROM.
- Drives the ROM's select lines as a program counter and samples the 2-bit instruction word the ROM returns.
- Executes INC (00), JNO (01) and HLT (10) against an internal accumulator.
- Sits directly on the ROM's sel1/sel2 inputs and out1/out2 outputs; it is the consumer end of that interface.

---
 rtl/inc_jno_sequencer.sv | 106 ++++++++++
 tb/tb_inc_jno_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/inc_jno_sequencer.sv
// inc_jno_sequencer: program reader/executor for a 4x2-bit ROM running INC, JNO and HLT on an accumulator.
// Define INSN_CNT_EN to add the retired-instruction counter port insn_count_o.
module inc_jno_sequencer #(
    parameter int ACC_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             instr_msb_i,
    input  logic             instr_lsb_i,
    output logic             sel1_o,
    output logic             sel2_o,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic             halted_o,
`ifdef INSN_CNT_EN
    output logic             illegal_o,
    output logic [CNT_W-1:0] insn_count_o
`else
    output logic             illegal_o
`endif
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, OPERAND, HALT} state_e;
    state_e state_q, state_d;
    logic [1:0] pc_q, pc_d, ir_q, ir_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic ovf_q, ovf_d, ill_q, ill_d, accept;
`ifdef INSN_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else state_q <= state_d;
    end
    assign accept = (state_q == IDLE || state_q == HALT) && start_i;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HALT: state_d = start_i ? FETCH : state_q;
            FETCH:      state_d = EXEC;
            EXEC:       state_d = ir_q == 2'b00 ? FETCH : ir_q == 2'b01 ? OPERAND : HALT;
            OPERAND:    state_d = FETCH;
            default:    state_d = IDLE;
        endcase
    end
    always_comb begin
        busy_o   = state_q == FETCH || state_q == EXEC || state_q == OPERAND;
        halted_o = state_q == HALT;
    end
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        acc_d = acc_q;
        ovf_d = ovf_q;
        ill_d = ill_q;
`ifdef INSN_CNT_EN
        cnt_d = cnt_q;
        if (accept) cnt_d = '0;
        else if (state_q == EXEC) cnt_d = cnt_q + 1'b1;
`endif
        if (accept) begin
            pc_d  = 2'd0;
            acc_d = '0;
            ovf_d = 1'b0;
            ill_d = 1'b0;
        end else if (state_q == FETCH) begin
            ir_d = {instr_msb_i, instr_lsb_i};
        end else if (state_q == EXEC) begin
            if (ir_q == 2'b00) {ovf_d, acc_d} = {1'b0, acc_q} + 1'b1;
            if (ir_q[1] == 1'b0) pc_d = pc_q + 2'd1;
            if (ir_q == 2'b11) ill_d = 1'b1;
        end else if (state_q == OPERAND) begin
            // the operand word is the jump target, taken only while no overflow is pending
            pc_d = ovf_q ? pc_q + 2'd1 : {instr_msb_i, instr_lsb_i};
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q  <= 2'd0;
            ir_q  <= 2'd0;
            acc_q <= '0;
            ovf_q <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            ill_q <= ill_d;
        end
    end
`ifdef INSN_CNT_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign insn_count_o = cnt_q;
`endif
    assign sel1_o    = pc_q[0];
    assign sel2_o    = pc_q[1];
    assign acc_o     = acc_q;
    assign ovf_o     = ovf_q;
    assign illegal_o = ill_q;
endmodule

// File: tb/tb_inc_jno_sequencer.sv
// tb_inc_jno_sequencer: runs fixed and random ROM programs on ACC_W=4 and ACC_W=2 instances against an instruction-level model.
module tb_inc_jno_sequencer;
    localparam int LIMIT = 300;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic [1:0] rom [4];
    logic [1:0] ins_a, ins_b;
    logic s1a, s2a, s1b, s2b;
    logic [3:0] acc_a;
    logic [1:0] acc_b;
    logic ovf_a, ovf_b, busy_a, busy_b, halt_a, halt_b, ill_a, ill_b;
`ifdef INSN_CNT_EN
    logic [7:0] cnt_a, cnt_b;
`endif
    int compared = 0, mismatched = 0;
    always #5 clk = ~clk;
    assign ins_a = rom[{s2a, s1a}];
    assign ins_b = rom[{s2b, s1b}];
    inc_jno_sequencer #(.ACC_W(4), .CNT_W(8)) dut_a (
        .clk_i(clk), .reset_i(reset), .start_i(start_a),
        .instr_msb_i(ins_a[1]), .instr_lsb_i(ins_a[0]),
        .sel1_o(s1a), .sel2_o(s2a), .acc_o(acc_a), .ovf_o(ovf_a),
        .busy_o(busy_a), .halted_o(halt_a),
`ifdef INSN_CNT_EN
        .insn_count_o(cnt_a),
`endif
        .illegal_o(ill_a)
    );
    inc_jno_sequencer #(.ACC_W(2), .CNT_W(8)) dut_b (
        .clk_i(clk), .reset_i(reset), .start_i(start_b),
        .instr_msb_i(ins_b[1]), .instr_lsb_i(ins_b[0]),
        .sel1_o(s1b), .sel2_o(s2b), .acc_o(acc_b), .ovf_o(ovf_b),
        .busy_o(busy_b), .halted_o(halt_b),
`ifdef INSN_CNT_EN
        .insn_count_o(cnt_b),
`endif
        .illegal_o(ill_b)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // Instruction-level reference: walks the program and sums per-instruction cycle costs.
    task automatic model(input int w, output int cyc, output int acc, output int ovf,
                         output int ill, output int pc, output int cnt, output bit halts);
        int mx, op;
        mx = (1 << w) - 1;
        cyc = 0; acc = 0; ovf = 0; ill = 0; pc = 0; cnt = 0; halts = 0;
        while (cyc <= LIMIT) begin
            op = int'(rom[pc]);
            cnt = (cnt + 1) % 256;
            if (op == 0) begin
                ovf = (acc == mx) ? 1 : 0;
                acc = (acc + 1) & mx;
                pc = (pc + 1) % 4;
                cyc += 2;
            end else if (op == 1) begin
                pc = (ovf != 0) ? (pc + 2) % 4 : int'(rom[(pc + 1) % 4]);
                cyc += 3;
            end else begin
                ill = (op == 3) ? 1 : 0;
                cyc += 2;
                halts = (cyc <= LIMIT);
                break;
            end
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic run(input bit hold);
        int ca, aa, oa, ia, pa, na, cb, ab, ob, ib, pb, nb, ea, eb;
        bit ha, hb;
        model(4, ca, aa, oa, ia, pa, na, ha);
        model(2, cb, ab, ob, ib, pb, nb, hb);
        @(negedge clk);
        start_a = 1'b1;
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = hold;
        start_b = hold;
        ea = 0;
        eb = 0;
        for (int k = 1; k <= LIMIT; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (halt_a && ea == 0) begin ea = k; start_a = 1'b0; end
            if (halt_b && eb == 0) begin eb = k; start_b = 1'b0; end
            if (ea != 0 && eb != 0) break;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        check("edges_a", ea, ha ? ca : 0);
        check("edges_b", eb, hb ? cb : 0);
        if (ha) begin
            check("acc_a", acc_a, aa);
            check("ovf_a", ovf_a, oa);
            check("ill_a", ill_a, ia);
            check("pc_a", {s2a, s1a}, pa);
            check("busy_a", busy_a, 0);
`ifdef INSN_CNT_EN
            check("cnt_a", cnt_a, na);
`endif
        end else check("busy_a_loop", busy_a, 1);
        if (hb) begin
            check("acc_b", acc_b, ab);
            check("ovf_b", ovf_b, ob);
            check("ill_b", ill_b, ib);
            check("pc_b", {s2b, s1b}, pb);
`ifdef INSN_CNT_EN
            check("cnt_b", cnt_b, nb);
`endif
        end else check("busy_b_loop", busy_b, 1);
        if (!ha || !hb) do_reset();
    endtask
    initial begin
        rom = '{2'd0, 2'd1, 2'd0, 2'd2};
        do_reset();
        check("rst_acc", acc_a, 0);
        check("rst_sel", {s2a, s1a}, 0);
        check("rst_busy", busy_a, 0);
        check("rst_halted", halt_a, 0);
        check("rst_ovf_ill", {ovf_a, ill_a}, 0);
        run(0);
        run(0);
        run(1);
        @(negedge clk);
        start_a = 1'b1;
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid_acc", acc_a, 0);
        check("mid_sel", {s2a, s1a}, 0);
        check("mid_busy", {busy_a, busy_b}, 0);
        check("mid_halted", halt_a, 0);
        run(0);
        rom = '{2'd3, 2'd0, 2'd1, 2'd0};
        run(0);
        rom = '{2'd1, 2'd3, 2'd0, 2'd2};
        run(0);
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 4; i++) rom[i] = 2'($urandom_range(0, 3));
            run(r % 3 == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
